// File: rtl/regfile_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_ctrl_pkg
// Brief    : Shared types and constants for the register-file write-back
//            controller.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_ctrl_pkg;

  // Controller phase: clearing the register file, then normal write-back.
  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } wb_state_e;

  // x0 is hardwired to zero; writes to it are consumed but never issued.
  localparam int REG_ZERO = 0;

  // Default register index width and the resulting register count.
  localparam int DEF_ADDR_W = 5;
  localparam int NUM_REGS   = 2 ** DEF_ADDR_W;

  // Register count for an arbitrary index width.
  function automatic int num_regs(input int addr_w);
    return 2 ** addr_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin arbiter. Combinational one-hot grant to the first
//            requester at or after the pointer; the pointer moves just past
//            the granted requester whenever a transfer is taken.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter  int N     = 3,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  input  logic [PTR_W-1:0] gnt_idx,
  output logic [N-1:0]     grant
);

  logic [PTR_W-1:0] rr_ptr;
  logic             found;

  // Pointer wraps at N (not at a power of two) after the granted requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (advance) begin
      if (gnt_idx == PTR_W'(N - 1)) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= gnt_idx + PTR_W'(1);
      end
    end
  end

  // Two-pass search: indices >= rr_ptr first, then wrap around from 0.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (PTR_W'(i) >= rr_ptr)) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Brief    : Write-back controller for the general register file. Clears
//            registers 1..NUM_REGS-1 after reset, then shares the single
//            write port among N_REQ sources with round-robin arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*ADDR_W-1:0] req_reg,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic                    rf_reg_write,
  output logic [ADDR_W-1:0]       rf_write_reg,
  output logic [DATA_W-1:0]       rf_write_data,
  output logic                    init_done
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(num_regs(ADDR_W) - 1);

  wb_state_e         state, state_nxt;
  logic [ADDR_W-1:0] init_cnt, init_cnt_nxt;
  logic              done_nxt;
  logic              we_nxt;
  logic [ADDR_W-1:0] wreg_nxt;
  logic [DATA_W-1:0] wdata_nxt;

  logic [N_REQ-1:0]  grant;
  logic [PTR_W-1:0]  gnt_idx;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;
  logic              advance;

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (advance),
    .gnt_idx (gnt_idx),
    .grant   (grant)
  );

  // Ready only in RUN; a transfer is any granted request while running.
  assign req_ready = (state == RUN) ? grant : '0;
  assign advance   = (state == RUN) && (|grant);

  // One-hot grant to index, destination and data of the winner.
  always_comb begin
    gnt_idx  = '0;
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        gnt_idx  = PTR_W'(i);
        sel_reg  = req_reg[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next state and next values of the registered write-port outputs.
  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    done_nxt     = init_done;
    we_nxt       = 1'b0;
    wreg_nxt     = rf_write_reg;
    wdata_nxt    = rf_write_data;
    case (state)
      INIT: begin
        we_nxt       = 1'b1;
        wreg_nxt     = init_cnt;
        wdata_nxt    = '0;
        init_cnt_nxt = init_cnt + ADDR_W'(1);
        if (init_cnt == LAST_REG) begin
          state_nxt = RUN;
          done_nxt  = 1'b1;
        end
      end
      RUN: begin
        if (advance) begin
          we_nxt    = (sel_reg != ADDR_W'(REG_ZERO));
          wreg_nxt  = sel_reg;
          wdata_nxt = sel_data;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  // State, clear counter and write-port output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= INIT;
      init_cnt      <= ADDR_W'(1);
      init_done     <= 1'b0;
      rf_reg_write  <= 1'b0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
    end else begin
      state         <= state_nxt;
      init_cnt      <= init_cnt_nxt;
      init_done     <= done_nxt;
      rf_reg_write  <= we_nxt;
      rf_write_reg  <= wreg_nxt;
      rf_write_data <= wdata_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Brief    : Directed self-checking bench for regfile_wb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  localparam int N_REQ  = 3;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic                    clk;
  logic                    rst_n;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*ADDR_W-1:0] req_reg;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic                    rf_reg_write;
  logic [ADDR_W-1:0]       rf_write_reg;
  logic [DATA_W-1:0]       rf_write_data;
  logic                    init_done;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(
    .N_REQ  (N_REQ),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_reg       (req_reg),
    .req_data      (req_data),
    .rf_reg_write  (rf_reg_write),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .init_done     (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    req_reg[i*ADDR_W +: ADDR_W]  = r;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_reg   = '0;
    req_data  = '0;
    tick();
    tick();
    check("rst_we",    32'(rf_reg_write),  32'd0);
    check("rst_reg",   32'(rf_write_reg),  32'd0);
    check("rst_data",  rf_write_data,      32'd0);
    check("rst_done",  32'(init_done),     32'd0);
    req_valid = 3'b111;
    #1;
    check("rst_ready", 32'(req_ready),     32'd0);

    // Clear sequence with requests asserted: they must be ignored.
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 31; e++) begin
      check("init_ready", 32'(req_ready), 32'd0);
      tick();
      check("init_we",   32'(rf_reg_write), 32'd1);
      check("init_reg",  32'(rf_write_reg), 32'(e));
      check("init_data", rf_write_data,     32'd0);
      check("init_done", 32'(init_done),    (e == 31) ? 32'd1 : 32'd0);
    end
    req_valid = '0;
    tick();
    check("idle_we",   32'(rf_reg_write), 32'd0);
    check("idle_reg",  32'(rf_write_reg), 32'd31);
    check("idle_done", 32'(init_done),    32'd1);

    // Single write: requester 1, reg 7.
    set_req(1, 5'd7, 32'hDEADBEEF);
    req_valid = 3'b010;
    #1;
    check("r1_ready", 32'(req_ready), 32'b010);
    tick();
    req_valid = '0;
    check("r1_we",   32'(rf_reg_write), 32'd1);
    check("r1_reg",  32'(rf_write_reg), 32'd7);
    check("r1_data", rf_write_data,     32'hDEADBEEF);
    tick();
    check("r1_we_off", 32'(rf_reg_write), 32'd0);
    check("r1_hold",   rf_write_data,     32'hDEADBEEF);

    // Write to x0 from requester 2 (pointer is at 2): consumed, suppressed.
    set_req(2, 5'd0, 32'h12345678);
    req_valid = 3'b100;
    #1;
    check("x0_ready", 32'(req_ready), 32'b100);
    tick();
    req_valid = '0;
    check("x0_we",   32'(rf_reg_write), 32'd0);
    check("x0_reg",  32'(rf_write_reg), 32'd0);
    check("x0_data", rf_write_data,     32'h12345678);

    // All requesters valid: pointer back at 0, grants rotate 0,1,2,0,1,2.
    set_req(0, 5'd3, 32'h0000_0100);
    set_req(1, 5'd4, 32'h0000_0101);
    set_req(2, 5'd5, 32'h0000_0102);
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr_ready", 32'(req_ready), 32'(1 << (k % 3)));
      tick();
      check("rr_we",   32'(rf_reg_write), 32'd1);
      check("rr_reg",  32'(rf_write_reg), 32'(3 + (k % 3)));
      check("rr_data", rf_write_data,     32'h100 + 32'(k % 3));
    end
    req_valid = '0;
    tick();
    check("rr_we_off", 32'(rf_reg_write), 32'd0);

    // Same destination from 0 and 1: serialized in grant order.
    set_req(0, 5'd9, 32'hA);
    set_req(1, 5'd9, 32'hB);
    req_valid = 3'b011;
    #1;
    check("wr9_ready0", 32'(req_ready), 32'b001);
    tick();
    req_valid = 3'b010;
    check("wr9_reg_a",  32'(rf_write_reg), 32'd9);
    check("wr9_data_a", rf_write_data,     32'hA);
    check("wr9_ready1", 32'(req_ready),    32'b010);
    tick();
    req_valid = '0;
    check("wr9_we_b",   32'(rf_reg_write), 32'd1);
    check("wr9_data_b", rf_write_data,     32'hB);
    tick();
    check("wr9_final", rf_write_data, 32'hB);
    check("wr9_we_off", 32'(rf_reg_write), 32'd0);

    // Reset with a write in flight on the output port.
    set_req(0, 5'd11, 32'h55);
    req_valid = 3'b001;
    tick();
    req_valid = '0;
    check("pend_we", 32'(rf_reg_write), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mrst_we",    32'(rf_reg_write), 32'd0);
    check("mrst_done",  32'(init_done),    32'd0);
    check("mrst_reg",   32'(rf_write_reg), 32'd0);
    check("mrst_ready", 32'(req_ready),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("reinit_we",   32'(rf_reg_write), 32'd1);
    check("reinit_reg",  32'(rf_write_reg), 32'd1);
    check("reinit_done", 32'(init_done),    32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
